// File: rtl/ahb2_pkg.sv
// Shared AHB2 encodings, slave FSM state type and the byte-lane enable helper
// used by the SRAM responder.
package ahb2_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        SLV_IDLE,
        SLV_WAIT,
        SLV_DATA,
        SLV_ERR1,
        SLV_ERR2
    } slv_state_e;

    // Little-endian lane enables; illegal sizes enable nothing.
    function automatic logic [3:0] ahb2_byte_en(input logic [2:0] hsize, input logic [1:0] addr);
        logic [3:0] be;
        be = 4'b0000;
        case (hsize)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb2_sram_slv_mem.sv
// Word-organised storage for the SRAM responder: one byte-enabled write port,
// one asynchronous read port, no reset on the contents.
module ahb2_sram_slv_mem #(
    parameter int MEM_WORDS = 768,
    parameter int IDX_W     = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    localparam int ROW_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [ROW_W-1:0] row;

    // The responder never reaches a data phase for an index >= MEM_WORDS,
    // so trimming the index to the array width is safe.
    assign row = ROW_W'(addr_i);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_q [MEM_WORDS];

            always_ff @(posedge clk) begin
                if (we_i && be_i[gi]) begin
                    lane_q[row] <= wdata_i[gi*8 +: 8];
                end
            end

            assign rdata_o[gi*8 +: 8] = lane_q[row];
        end
    endgenerate

endmodule

// File: rtl/ahb2_sram_slv.sv
// AHB2 slave responder in front of an on-chip word memory: address-phase
// decode and error check, programmable wait states, two-cycle ERROR response.
module ahb2_sram_slv
    import ahb2_pkg::*;
#(
    parameter int MEM_WORDS   = 768,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hreadyi,
    output logic [31:0] hrdata,
    output logic        hreadyo,
    output logic [1:0]  hresp
);

    localparam int         IDX_W     = ADDR_WIDTH - 2;
    localparam logic [3:0] WCNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    slv_state_e            state_q, state_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            size_q;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  accept;
    logic                  req_err;
    logic                  take_new;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [31:0]           mem_rdata;
    logic                  unused_ok;

    assign offset = haddr[ADDR_WIDTH-1:0];
    assign accept = hsel && hreadyi && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    // Burst type, protection and the decoder-owned upper address are don't-cares here.
    assign unused_ok = ^{hburst, hprot, haddr[31:ADDR_WIDTH]};

    always_comb begin
        req_err = 1'b0;
        if (hsize > HSIZE_WORD) begin
            req_err = 1'b1;
        end
        if ((hsize == HSIZE_HALF) && offset[0]) begin
            req_err = 1'b1;
        end
        if ((hsize == HSIZE_WORD) && (offset[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
        if (32'(offset[ADDR_WIDTH-1:2]) >= 32'(MEM_WORDS)) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        hreadyo  = 1'b1;
        hresp    = HRESP_OKAY;
        take_new = 1'b0;

        case (state_q)
            SLV_IDLE: begin
                take_new = 1'b1;
            end
            SLV_WAIT: begin
                hreadyo = 1'b0;
                if (wcnt_q == 4'd0) begin
                    state_d = SLV_DATA;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            SLV_DATA: begin
                take_new = 1'b1;
            end
            SLV_ERR1: begin
                hreadyo = 1'b0;
                hresp   = HRESP_ERROR;
                state_d = SLV_ERR2;
            end
            SLV_ERR2: begin
                hresp    = HRESP_ERROR;
                take_new = 1'b1;
            end
            default: begin
                state_d = SLV_IDLE;
            end
        endcase

        // Completing cycles may overlap the next address phase (pipelining).
        if (take_new) begin
            if (!accept) begin
                state_d = SLV_IDLE;
            end else if (req_err) begin
                state_d = SLV_ERR1;
            end else if (WAIT_CYCLES == 0) begin
                state_d = SLV_DATA;
            end else begin
                state_d = SLV_WAIT;
                wcnt_d  = WCNT_INIT;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= SLV_IDLE;
            wcnt_q  <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= HSIZE_BYTE;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (take_new && accept) begin
                addr_q  <= offset;
                write_q <= hwrite;
                size_q  <= hsize;
            end
        end
    end

    // A reset landing on the write data phase drops the write.
    assign mem_we = (state_q == SLV_DATA) && write_q && !hreset;
    assign mem_be = ahb2_byte_en(size_q, addr_q[1:0]);

    ahb2_sram_slv_mem #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk     (hclk),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .addr_i  (addr_q[ADDR_WIDTH-1:2]),
        .wdata_i (hwdata),
        .rdata_o (mem_rdata)
    );

    assign hrdata = ((state_q == SLV_DATA) && !write_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_ahb2_sram_slv.sv
// Directed bench for ahb2_sram_slv: three instances with 0, 3 and 2 wait states
// share one bus; dsel steers hsel to the instance under test.
module tb_ahb2_sram_slv;
    import ahb2_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hreadyi;
    logic [1:0]  dsel;

    logic [31:0] rdata_w [3];
    logic        ready_w [3];
    logic [1:0]  resp_w  [3];

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int WC = (gi == 0) ? 0 : ((gi == 1) ? 3 : 2);
            logic sel_g;
            assign sel_g = hsel && (dsel == gi);

            ahb2_sram_slv #(
                .MEM_WORDS   (768),
                .ADDR_WIDTH  (12),
                .WAIT_CYCLES (WC)
            ) u_dut (
                .hclk    (hclk),
                .hreset  (hreset),
                .hsel    (sel_g),
                .haddr   (haddr),
                .htrans  (htrans),
                .hwrite  (hwrite),
                .hsize   (hsize),
                .hburst  (hburst),
                .hprot   (hprot),
                .hwdata  (hwdata),
                .hreadyi (hreadyi),
                .hrdata  (rdata_w[gi]),
                .hreadyo (ready_w[gi]),
                .hresp   (resp_w[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic rdy, input logic [1:0] resp, input logic [31:0] rdata);
        check({tag, "/hreadyo"}, {31'b0, ready_w[dsel]}, {31'b0, rdy});
        check({tag, "/hresp"},   {30'b0, resp_w[dsel]},  {30'b0, resp});
        check({tag, "/hrdata"},  rdata_w[dsel],          rdata);
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_bus();
        hsel    = 1'b0;
        htrans  = HTRANS_IDLE;
        hreadyi = 1'b1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
        hsel    = 1'b1;
        htrans  = HTRANS_NONSEQ;
        haddr   = a;
        hwrite  = wr;
        hsize   = sz;
        hreadyi = 1'b1;
    endtask

    // Single non-pipelined OKAY transfer with nwait stall cycles.
    task automatic xfer(input string tag, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                        input logic [31:0] wdata, input int nwait, input logic [31:0] exp_rd);
        addr_phase(a, wr, sz);
        tick();
        idle_bus();
        hwdata = wdata;
        for (int i = 0; i < nwait; i++) begin
            hreadyi = 1'b0;
            check({tag, "/stall"}, {31'b0, ready_w[dsel]}, 32'h0);
            tick();
        end
        hreadyi = 1'b1;
        check_st(tag, 1'b1, HRESP_OKAY, wr ? 32'h0 : exp_rd);
        $display("dut%0d %s %s addr=0x%03h size=%0d data=0x%08h", dsel, tag, wr ? "WR" : "RD",
                 a[11:0], sz, wr ? wdata : rdata_w[dsel]);
        tick();
    endtask

    task automatic err_xfer(input string tag, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                            input logic [31:0] wdata);
        addr_phase(a, wr, sz);
        tick();
        idle_bus();
        hreadyi = 1'b0;
        hwdata  = wdata;
        check_st({tag, "/err1"}, 1'b0, HRESP_ERROR, 32'h0);
        tick();
        hreadyi = 1'b1;
        check_st({tag, "/err2"}, 1'b1, HRESP_ERROR, 32'h0);
        $display("dut%0d %s ERR %s addr=0x%03h size=%0d", dsel, tag, wr ? "WR" : "RD", a[11:0], sz);
        tick();
        check_st({tag, "/after"}, 1'b1, HRESP_OKAY, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dsel   = 2'd0;
        hburst = 3'b000;
        hprot  = 4'b0011;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        hwdata = 32'h0;
        idle_bus();
        hreset = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            dsel = 2'(d);
            check_st("reset", 1'b1, HRESP_OKAY, 32'h0);
        end
        hreset = 1'b0;
        dsel   = 2'd0;
        tick();

        // Pipelined write then read of the same word, zero waits.
        addr_phase(32'h010, 1'b1, HSIZE_WORD);
        tick();
        hwdata = 32'hDEADBEEF;
        addr_phase(32'h010, 1'b0, HSIZE_WORD);
        check_st("t1 wr dphase", 1'b1, HRESP_OKAY, 32'h0);
        $display("dut0 t1 WR addr=0x010 data=0xdeadbeef (pipelined)");
        tick();
        idle_bus();
        check_st("t1 rd dphase", 1'b1, HRESP_OKAY, 32'hDEADBEEF);
        $display("dut0 t1 RD addr=0x010 data=0x%08h", rdata_w[0]);
        tick();
        check_st("t1 idle", 1'b1, HRESP_OKAY, 32'h0);

        // Byte-lane enables: stray lanes in hwdata must not land.
        xfer("t2 clr",  32'h010, 1'b1, HSIZE_WORD, 32'h0000_0000, 0, 32'h0);
        xfer("t2 byte", 32'h013, 1'b1, HSIZE_BYTE, 32'hAABB_CCDD, 0, 32'h0);
        xfer("t2 half", 32'h010, 1'b1, HSIZE_HALF, 32'h9988_5555, 0, 32'h0);
        xfer("t2 rdw",  32'h010, 1'b0, HSIZE_WORD, 32'h0, 0, 32'hAA00_5555);
        xfer("t2 rdb",  32'h011, 1'b0, HSIZE_BYTE, 32'h0, 0, 32'hAA00_5555);

        // BUSY with hsel is a zero-wait OKAY and starts nothing.
        hsel   = 1'b1;
        htrans = HTRANS_BUSY;
        haddr  = 32'h010;
        hwrite = 1'b0;
        tick();
        idle_bus();
        check_st("busy", 1'b1, HRESP_OKAY, 32'h0);
        tick();

        // Error rules; errored write leaves memory alone.
        err_xfer("t4 misw",  32'h012, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF);
        err_xfer("t4 mish",  32'h011, 1'b1, HSIZE_HALF, 32'hFFFF_FFFF);
        err_xfer("t4 size3", 32'h010, 1'b0, 3'b011,     32'h0);
        xfer("t4 rdback", 32'h010, 1'b0, HSIZE_WORD, 32'h0, 0, 32'hAA00_5555);

        // Last legal word, then one past it with a pipelined read during ERR2.
        xfer("t5 wr4",   32'h004, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, 0, 32'h0);
        xfer("t5 wrtop", 32'hBFC, 1'b1, HSIZE_WORD, 32'h7654_3210, 0, 32'h0);
        xfer("t5 rdtop", 32'hBFC, 1'b0, HSIZE_WORD, 32'h0, 0, 32'h7654_3210);
        addr_phase(32'hC00, 1'b0, HSIZE_WORD);
        tick();
        idle_bus();
        hreadyi = 1'b0;
        check_st("t5 oob err1", 1'b0, HRESP_ERROR, 32'h0);
        tick();
        addr_phase(32'h004, 1'b0, HSIZE_WORD);
        check_st("t5 oob err2", 1'b1, HRESP_ERROR, 32'h0);
        $display("dut0 t5 ERR RD addr=0xc00, pipelined RD addr=0x004");
        tick();
        idle_bus();
        check_st("t5 pipe rd", 1'b1, HRESP_OKAY, 32'hCAFE_F00D);
        tick();

        // Reset during a write data phase discards the write.
        addr_phase(32'h004, 1'b1, HSIZE_WORD);
        tick();
        idle_bus();
        hwdata = 32'h0000_0000;
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        check_st("rst dphase", 1'b1, HRESP_OKAY, 32'h0);
        $display("dut0 reset during WR data phase addr=0x004");
        xfer("rst rdback", 32'h004, 1'b0, HSIZE_WORD, 32'h0, 0, 32'hCAFE_F00D);

        // Three wait states; a NONSEQ held during the stall with hreadyi low is not accepted.
        dsel = 2'd1;
        xfer("t3 wr", 32'h020, 1'b1, HSIZE_WORD, 32'h1234_5678, 3, 32'h0);
        addr_phase(32'h020, 1'b0, HSIZE_WORD);
        tick();
        haddr   = 32'h024;
        hreadyi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_st("t3 stall", 1'b0, HRESP_OKAY, 32'h0);
            tick();
        end
        idle_bus();
        check_st("t3 rd dphase", 1'b1, HRESP_OKAY, 32'h1234_5678);
        $display("dut1 t3 RD addr=0x020 data=0x%08h after 3 waits", rdata_w[1]);
        tick();
        check_st("t3 no accept", 1'b1, HRESP_OKAY, 32'h0);

        // Two wait states: reset during WAIT of a write, error path has no waits.
        dsel = 2'd2;
        xfer("t6 prior", 32'h030, 1'b1, HSIZE_WORD, 32'h0BAD_CAFE, 2, 32'h0);
        addr_phase(32'h030, 1'b1, HSIZE_WORD);
        tick();
        idle_bus();
        hreadyi = 1'b0;
        hwdata  = 32'h55AA_55AA;
        check_st("t6 wait", 1'b0, HRESP_OKAY, 32'h0);
        hreset = 1'b1;
        tick();
        check_st("t6 reset", 1'b1, HRESP_OKAY, 32'h0);
        $display("dut2 t6 reset during WAIT of WR addr=0x030");
        hreset  = 1'b0;
        hreadyi = 1'b1;
        tick();
        xfer("t6 rdback", 32'h030, 1'b0, HSIZE_WORD, 32'h0, 2, 32'h0BAD_CAFE);
        err_xfer("t6 misw", 32'h031, 1'b0, HSIZE_WORD, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb2_sram_slv.md
Name: ahb2_sram_slv

Overview:
- AHB2 (AMBA2 AHB, ARM IHI 0011A) slave-side responder: the responder end of the AHB2 slave interface (slave-modport signal set).
- Backs a word-organised on-chip memory.
- Supports byte, halfword and word accesses, programmable wait states, and the two-cycle ERROR response.
- Sits behind the AHB2 address decoder and slave mux; used as scratch SRAM and as the default memory target in subsystem benches.

Parameters:
MEM_WORDS, 768, number of 32-bit words implemented; need not be a power of two.
ADDR_WIDTH, 12, offset bits decoded from haddr (byte address); requires 4*MEM_WORDS <= 2**ADDR_WIDTH.
WAIT_CYCLES, 0, wait states inserted in every OKAY data phase (0..15).

Ports:
hclk  input  1  bus clock, all logic on rising edge
hreset  input  1  synchronous, active-high reset
hsel  input  1  slave select from decoder
haddr  input  32  byte address
htrans  input  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
hwrite  input  1  1=write
hsize  input  3  000 byte, 001 halfword, 010 word, others illegal
hburst  input  3  ignored
hprot  input  4  ignored
hwdata  input  32  write data, sampled in the write data phase
hreadyi  input  1  bus HREADY; previous transfer complete
hrdata  output  32  read data
hreadyo  output  1  this slave's HREADY
hresp  output  2  OKAY=00 ERROR=01 RETRY=10 SPLIT=11 (RETRY/SPLIT never driven)

Behaviour:
- **Accept:** an address phase is accepted on a clock edge where hsel & hreadyi & htrans[1]. On accept, register offset = haddr[ADDR_WIDTH-1:0], hwrite and hsize. No accept occurs while hreadyi=0.
- **Ignored transfers:** IDLE/BUSY with hsel, and any unselected cycle, get a zero-wait OKAY.
- **Error check (decided at accept):**
  - hsize > 010;
  - halfword with offset[0]=1;
  - word with offset[1:0]!=0;
  - offset[ADDR_WIDTH-1:2] >= MEM_WORDS.
- **FSM states:** IDLE, WAIT, DATA, ERR1, ERR2.
- **IDLE:**
  - Outputs: hreadyo=1, hresp=OKAY.
  - Accept with error -> ERR1.
  - Accept, no error, WAIT_CYCLES=0 -> DATA.
  - Accept, no error, otherwise -> WAIT with wcnt=WAIT_CYCLES-1.
- **WAIT:**
  - Outputs: hreadyo=0, hresp=OKAY.
  - wcnt decrements each cycle; at wcnt=0 -> DATA.
- **DATA:**
  - Outputs: hreadyo=1, hresp=OKAY.
  - Read: hrdata = mem[word] unshifted; the master selects byte lanes (little-endian).
  - Write: at the end of the cycle, hwdata lanes are written under byte enables derived from hsize and offset[1:0].
  - Next state: a new accept in the same cycle (pipelined) -> ERR1/WAIT/DATA as from IDLE; otherwise IDLE.
- **ERR1:** hreadyo=0, hresp=ERROR -> ERR2.
- **ERR2:**
  - Outputs: hreadyo=1, hresp=ERROR.
  - Accept in the same cycle is handled as from DATA.
  - Errored writes never modify memory.
  - A master cancelling to IDLE during ERR2 is legal; ERR2 completes regardless.
- **Latency:** zero-wait transfer completes in the cycle after accept. With N=WAIT_CYCLES, hreadyo is low for N cycles. Error response is always exactly 2 cycles with no wait states.
- **hrdata:** 0 except in a read DATA cycle.
- **Read-after-write:** back-to-back write then read to the same word returns the new data. The write commits at the end of the write data phase, before the read data phase.
- **Reset:**
  - hreadyo=1, hresp=OKAY, hrdata=0, state IDLE, wcnt=0.
  - Reset mid-transfer aborts it; a pending write is discarded.
  - Memory contents are not reset and are undefined until written.
- **Bursts:** each beat is checked and addressed independently; no wrap or boundary checking beyond the error rules.

Decomposition:
- **Package ahb2_pkg:**
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HRESP_OKAY/ERROR/RETRY/SPLIT;
  - HSIZE_BYTE/HALF/WORD;
  - slave FSM state enum;
  - function ahb2_byte_en(hsize, addr[1:0]) returning a 4-bit enable.
- **Sub-module ahb2_sram_slv_mem:**
  - MEM_WORDS x 32 flop array;
  - one write port with 4-bit byte enable;
  - one asynchronous read port.
- **Top level:** FSM, error check, wait counter.

Test Plan:
1. WAIT_CYCLES=0: write word 0xDEADBEEF @0x010, then read @0x010 back-to-back pipelined -> write data phase hreadyo=1 OKAY; next cycle hrdata=0xDEADBEEF, no stall.
2. Byte write 0xAA to @0x013, then halfword 0x5555 to @0x010 (lanes 1:0), then word read @0x010 -> hrdata=0xAA005555, given 0x00000000 prewritten.
3. WAIT_CYCLES=3: word read @0x020 -> hreadyo low exactly 3 cycles, then 1 with OKAY and valid data; hreadyi held low by the bench during stall → no new accept.
4. Word write @0x012 (misaligned) -> hreadyo=0/hresp=01, then hreadyo=1/hresp=01; word @0x010 unchanged on readback.
5. Read @0xC00 with MEM_WORDS=768 -> two-cycle ERROR. Pipelined NONSEQ read @0x004 during ERR2 -> OKAY next cycle.
6. Assert hreset during WAIT of a write @0x030 (WAIT_CYCLES=2) -> next cycle hreadyo=1, hresp=00, hrdata=0; readback of @0x030 returns the prior value.
